// File: rtl/instruction_queue_if.sv
// Fetch/decoder-side bundle of the instruction queue; slave is the queue, master the fetch/decode environment.
// Widths default to the 32-bit instruction and address sizes.
interface instruction_queue_if #(
   parameter int IDW = 32,
   parameter int AW  = 32
);
   logic           rdy_in;
   logic           if_instqueue_en_in;
   logic [IDW-1:0] if_instqueue_inst_in;
   logic [AW-1:0]  if_instqueue_pc_in;
   logic           instqueue_if_full_out;
   logic           instqueue_decoder_en_out;
   logic [IDW-1:0] instqueue_decoder_inst_out;
   logic [AW-1:0]  instqueue_decoder_pc_out;
   logic           decoder_instqueue_rst_in;
   logic           rob_instqueue_rst_in;
   logic           dispatcher_instqueue_stall_in;

   modport slave (
      input  rdy_in,
      input  if_instqueue_en_in,
      input  if_instqueue_inst_in,
      input  if_instqueue_pc_in,
      output instqueue_if_full_out,
      output instqueue_decoder_en_out,
      output instqueue_decoder_inst_out,
      output instqueue_decoder_pc_out,
      input  decoder_instqueue_rst_in,
      input  rob_instqueue_rst_in,
      input  dispatcher_instqueue_stall_in
   );

   modport master (
      output rdy_in,
      output if_instqueue_en_in,
      output if_instqueue_inst_in,
      output if_instqueue_pc_in,
      input  instqueue_if_full_out,
      input  instqueue_decoder_en_out,
      input  instqueue_decoder_inst_out,
      input  instqueue_decoder_pc_out,
      output decoder_instqueue_rst_in,
      output rob_instqueue_rst_in,
      output dispatcher_instqueue_stall_in
   );
endinterface

// File: rtl/instruction_queue.sv
// Circular {inst, pc} FIFO between fetch and decode; head shown combinationally, one-cycle push-to-head latency.
// Fetch is throttled by full_out (pushes when full are dropped); dispatcher stall holds the head.
module instruction_queue #(
   parameter int DEPTH     = 16,
   parameter int DEPTH_LOG = 4,
   parameter int IDW       = 32,
   parameter int AW        = 32
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   instruction_queue_if.slave   bus
);
   localparam logic [DEPTH_LOG:0] LP_FULL = (DEPTH_LOG+1)'(DEPTH);

   logic [IDW-1:0]       r_inst [DEPTH];
   logic [AW-1:0]        r_pc   [DEPTH];
   logic [DEPTH_LOG-1:0] r_head;
   logic [DEPTH_LOG-1:0] r_tail;
   logic [DEPTH_LOG:0]   r_count;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_flush;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == LP_FULL);

   // A ROB flush kills the dispatch in the same cycle; a decoder redirect still consumes the JAL.
   assign w_pop   = bus.rdy_in && !w_empty && !bus.dispatcher_instqueue_stall_in
                    && !bus.rob_instqueue_rst_in;
   assign w_push  = bus.rdy_in && bus.if_instqueue_en_in && !w_full;
   assign w_flush = bus.rdy_in && (bus.decoder_instqueue_rst_in || bus.rob_instqueue_rst_in);

   always_comb begin
      bus.instqueue_decoder_en_out   = 1'b0;
      bus.instqueue_decoder_inst_out = '0;
      bus.instqueue_decoder_pc_out   = '0;
      bus.instqueue_if_full_out      = 1'b0;
      if (!rst_in) begin
         bus.instqueue_decoder_en_out = w_pop;
         bus.instqueue_if_full_out    = w_full;
         if (!w_empty) begin
            bus.instqueue_decoder_inst_out = r_inst[r_head];
            bus.instqueue_decoder_pc_out   = r_pc[r_head];
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (w_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop)  r_head <= r_head + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   // Entry storage needs no reset; validity is tracked entirely by the pointers.
   always_ff @(posedge clk_in) begin
      if (w_push && !w_flush) begin
         r_inst[r_tail] <= bus.if_instqueue_inst_in;
         r_pc[r_tail]   <= bus.if_instqueue_pc_in;
      end
   end
endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue with a scoreboard queue of expected head entries.
module tb_instruction_queue;
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instruction_queue_if bus ();
   instruction_queue dut (.clk_in(clk), .rst_in(rst), .bus(bus));

   ent_t exp_q[$];
   int   n_asrt = 0;
   int   n_fail = 0;
   int   n_drop = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic push, input logic [31:0] inst, input logic [31:0] pc,
                        input logic stall, input logic dec, input logic rob, input logic rdy);
      bus.if_instqueue_en_in            = push;
      bus.if_instqueue_inst_in          = inst;
      bus.if_instqueue_pc_in            = pc;
      bus.dispatcher_instqueue_stall_in = stall;
      bus.decoder_instqueue_rst_in      = dec;
      bus.rob_instqueue_rst_in          = rob;
      bus.rdy_in                        = rdy;
   endtask

   // Check outputs mid-cycle against the scoreboard, then advance it across the next edge.
   task automatic tick(input string tag);
      logic exp_en;
      logic full_b;
      ent_t e;
      @(negedge clk);
      full_b = (exp_q.size() == 16);
      exp_en = bus.rdy_in && (exp_q.size() > 0) && !bus.dispatcher_instqueue_stall_in
               && !bus.rob_instqueue_rst_in;
      chk({tag, ".en"}, {31'd0, bus.instqueue_decoder_en_out}, {31'd0, exp_en});
      chk({tag, ".full"}, {31'd0, bus.instqueue_if_full_out}, {31'd0, full_b});
      if (exp_q.size() > 0) begin
         chk({tag, ".inst"}, bus.instqueue_decoder_inst_out, exp_q[0].inst);
         chk({tag, ".pc"}, bus.instqueue_decoder_pc_out, exp_q[0].pc);
      end else begin
         chk({tag, ".inst0"}, bus.instqueue_decoder_inst_out, 32'd0);
         chk({tag, ".pc0"}, bus.instqueue_decoder_pc_out, 32'd0);
      end
      if (bus.rdy_in && (bus.decoder_instqueue_rst_in || bus.rob_instqueue_rst_in)) begin
         exp_q.delete();
      end else begin
         if (exp_en) e = exp_q.pop_front();
         if (bus.rdy_in && bus.if_instqueue_en_in) begin
            if (!full_b) exp_q.push_back({bus.if_instqueue_inst_in, bus.if_instqueue_pc_in});
            else n_drop++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      #12;
      chk("rst.en", {31'd0, bus.instqueue_decoder_en_out}, 32'd0);
      chk("rst.full", {31'd0, bus.instqueue_if_full_out}, 32'd0);
      chk("rst.pc", bus.instqueue_decoder_pc_out, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick("idle");

      // Reset mid-operation with 5 entries loaded
      for (int i = 0; i < 5; i++)
         begin drive(1'b1, 32'h1000 + i, 32'h200 + 4 * i, 1'b1, 1'b0, 1'b0, 1'b1); tick("load5"); end
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      chk("pre_rst.en", {31'd0, bus.instqueue_decoder_en_out}, 32'd1);
      chk("pre_rst.pc", bus.instqueue_decoder_pc_out, 32'h200);
      rst = 1'b1;
      #1;
      chk("midrst.en", {31'd0, bus.instqueue_decoder_en_out}, 32'd0);
      chk("midrst.inst", bus.instqueue_decoder_inst_out, 32'd0);
      chk("midrst.pc", bus.instqueue_decoder_pc_out, 32'd0);
      chk("midrst.full", {31'd0, bus.instqueue_if_full_out}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      tick("post_rst");

      // Ordered flow
      drive(1'b1, 32'h00000013, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick("flow0");
      chk("flow.first_visible", {31'd0, bus.instqueue_decoder_en_out}, 32'd1);
      drive(1'b1, 32'h00100093, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1); tick("flow1");
      drive(1'b1, 32'h00200113, 32'h8, 1'b0, 1'b0, 1'b0, 1'b1); tick("flow2");
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) tick("flow_drain");
      chk("flow.empty", {31'd0, bus.instqueue_decoder_en_out}, 32'd0);

      // Fill to full under stall, drop the 17th, drain, then stream across the wrap
      for (int i = 0; i < 16; i++)
         begin drive(1'b1, 32'hA000 + i, 4 * i, 1'b1, 1'b0, 1'b0, 1'b1); tick("fill"); end
      chk("full.flag", {31'd0, bus.instqueue_if_full_out}, 32'd1);
      drive(1'b1, 32'hDEAD, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1); tick("push17");
      chk("full.drop17", n_drop, 32'd1);
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) tick("drain16");
      for (int i = 0; i < 20; i++)
         begin drive(1'b1, 32'hB000 + i, 32'h300 + 4 * i, 1'b0, 1'b0, 1'b0, 1'b1); tick("wrap"); end
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick("wrap_last");
      chk("wrap.empty", {31'd0, bus.instqueue_decoder_en_out}, 32'd0);

      // Stall holds the head for 4 cycles with 3 entries
      for (int i = 0; i < 3; i++)
         begin drive(1'b1, 32'hC000 + i, 32'h500 + 4 * i, 1'b1, 1'b0, 1'b0, 1'b1); tick("st_load"); end
      drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick("stall");
         chk("stall.head_pc", bus.instqueue_decoder_pc_out, 32'h500);
      end
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) tick("st_drain");
      chk("stall.count3", {31'd0, bus.instqueue_decoder_en_out}, 32'd0);

      // Decoder redirect with JAL at head and a concurrent push
      drive(1'b1, 32'h0080006F, 32'h10, 1'b1, 1'b0, 1'b0, 1'b1); tick("jal");
      for (int i = 1; i < 4; i++)
         begin drive(1'b1, 32'hE000 + i, 32'h10 + 4 * i, 1'b1, 1'b0, 1'b0, 1'b1); tick("behind"); end
      drive(1'b1, 32'hF00D, 32'h20, 1'b0, 1'b1, 1'b0, 1'b1); tick("dec_flush");
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick("after_dec");
      drive(1'b1, 32'h1234, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1); tick("refill");
      chk("dec.fresh_head", bus.instqueue_decoder_pc_out, 32'h100);
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick("refill_drain");

      // ROB flush with rdy_in toggling
      for (int i = 0; i < 2; i++)
         begin drive(1'b1, 32'h7000 + i, 32'h600 + 4 * i, 1'b1, 1'b0, 1'b0, 1'b1); tick("rob_load"); end
      drive(1'b1, 32'h9999, 32'h999, 1'b0, 1'b1, 1'b1, 1'b0); tick("rdy_low");
      chk("rdy_low.held", bus.instqueue_decoder_pc_out, 32'h600);
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1); tick("rob_flush");
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick("rob_after");
      chk("rob.empty_pc", bus.instqueue_decoder_pc_out, 32'd0);
      chk("drops_total", n_drop, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
